// File: rtl/soda_pkg.sv
// Shared constants and fp32 arithmetic helpers for the SODA cross-stencil datapath.
// Rounding mode: define FP_ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncation.
package soda_pkg;
   localparam int BW         = 32;
   localparam int ST         = 2;
   localparam int ROW        = 8;
   localparam int COL        = 8;
   localparam int NUM_POINTS = 5;
   localparam int LATENCY    = 4;
   localparam int WPR        = COL / ST;
   localparam int RW         = $clog2(ROW);
   localparam int WW         = $clog2(WPR);
   localparam int W_N        = 0;
   localparam int W_W        = 1;
   localparam int W_C        = 2;
   localparam int W_E        = 3;
   localparam int W_S        = 4;
   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
`ifdef FP_ROUND_NEAREST_EN
   localparam bit FP_RNE = 1'b1;
`else
   localparam bit FP_RNE = 1'b0;
`endif

   // mant carries the hidden bit at [23]; underflow flushes to a signed zero.
   function automatic logic [31:0] fp32_pack(input logic s, input logic signed [10:0] e_in,
                                             input logic [23:0] mant, input logic guard,
                                             input logic sticky);
      logic signed [10:0] e;
      logic [24:0]        m;
      e = e_in;
      m = {1'b0, mant} + {24'd0, FP_RNE & guard & (sticky | mant[0])};
      if (m[24]) begin
         m = m >> 1;
         e = e + 11'sd1;
      end
      if (e >= 11'sd255)   return {s, 8'hFF, 23'd0};
      else if (e <= 11'sd0) return {s, 31'd0};
      else                  return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sr;
      logic [47:0]        prod;
      logic signed [10:0] e;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      sr     = a[31] ^ b[31];
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_CANON_NAN;
      if (a_inf || b_inf)   return {sr, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {sr, 31'd0};
      prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e    = $signed({3'd0, a[30:23]}) + $signed({3'd0, b[30:23]}) - 11'sd127;
      if (prod[47]) return fp32_pack(sr, e + 11'sd1, prod[47:24], prod[23], |prod[22:0]);
      else          return fp32_pack(sr, e, prod[46:23], prod[22], |prod[21:0]);
   endfunction

   function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, found;
      logic [31:0]        big, sml;
      logic [7:0]         d;
      logic [26:0]        m_big, m_sml, m_al, mask, n;
      logic [27:0]        sum;
      logic [4:0]         lz;
      logic signed [10:0] e;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return FP_CANON_NAN;
      if (a_inf)             return {a[31], 8'hFF, 23'd0};
      if (b_inf)             return {b[31], 8'hFF, 23'd0};
      if (a_zero && b_zero)  return {a[31] & b[31], 31'd0};
      if (a_zero)            return b;
      if (b_zero)            return a;
      if (a[30:0] >= b[30:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d     = big[30:23] - sml[30:23];
      m_big = {1'b1, big[22:0], 3'd0};
      m_sml = {1'b1, sml[22:0], 3'd0};
      // Three guard bits plus a sticky LSB keep the aligned operand exact enough for any rounding.
      if (d >= 8'd27) begin
         m_al = 27'd1;
      end else begin
         mask = (27'd1 << d) - 27'd1;
         m_al = (m_sml >> d) | {26'd0, |(m_sml & mask)};
      end
      if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_al};
      else                    sum = {1'b0, m_big} - {1'b0, m_al};
      if (sum == 28'd0) return 32'd0;
      e = $signed({3'd0, big[30:23]});
      if (sum[27]) begin
         n = sum[27:1] | {26'd0, sum[0]};
         e = e + 11'sd1;
      end else begin
         lz    = 5'd0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz = lz + 5'd1;
            end
         end
         n = sum[26:0] << lz;
         e = e - $signed({6'd0, lz});
      end
      return fp32_pack(big[31], e, n[26:3], n[2], |n[1:0]);
   endfunction
endpackage

// File: rtl/fp32_mul_add_lane.sv
// One output element: five fp32 products, then ((N+W)+(C+E))+S over three add stages.
module fp32_mul_add_lane
   import soda_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_en_out,
   input  logic [NUM_POINTS*BW-1:0] i_x,
   input  logic [NUM_POINTS*BW-1:0] i_wt,
   output logic [BW-1:0]            o_data
);
   logic [BW-1:0] w_prod [NUM_POINTS];
   logic [BW-1:0] r_prod [NUM_POINTS];
   logic [BW-1:0] r_nw;
   logic [BW-1:0] r_ce;
   logic [BW-1:0] r_s2;
   logic [BW-1:0] r_inner;
   logic [BW-1:0] r_s3;
   logic [BW-1:0] r_out;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_POINTS; gi++) begin : g_mul
         assign w_prod[gi] = fp32_mul(i_x[gi*BW +: BW], i_wt[gi*BW +: BW]);
      end
   endgenerate

   always_ff @(posedge clock) begin
      r_prod  <= w_prod;
      r_nw    <= fp32_add(r_prod[W_N], r_prod[W_W]);
      r_ce    <= fp32_add(r_prod[W_C], r_prod[W_E]);
      r_s2    <= r_prod[W_S];
      r_inner <= fp32_add(r_nw, r_ce);
      r_s3    <= r_s2;
   end

   // Only the final stage is gated, so the port holds the last valid result.
   always_ff @(posedge clock) begin
      if (reset)         r_out <= '0;
      else if (i_en_out) r_out <= fp32_add(r_inner, r_s3);
   end

   assign o_data = r_out;
endmodule

// File: rtl/soda_2d_cross_stencil.sv
// Streaming 5-point cross stencil over an 8x8 fp32 frame, ST elements per word, two row buffers.
// Rounding of the arithmetic follows FP_ROUND_NEAREST_EN (see soda_pkg).
module soda_2d_cross_stencil
   import soda_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_in_ready,
   input  logic [ST*BW-1:0]         io_in_matrix,
   input  logic [NUM_POINTS*BW-1:0] io_in_weight,
   output logic [ST*BW-1:0]         io_out_data,
   output logic                     io_out_valid
);
   localparam logic [WW-1:0] LAST_WORD      = WW'(WPR - 1);
   localparam logic [RW-1:0] LAST_ROW       = RW'(ROW - 1);
   localparam logic [RW-1:0] FIRST_TRIG_ROW = RW'(2);

   logic [RW-1:0]            r_row;
   logic [WW-1:0]            r_word;
   logic [ST*BW-1:0]         r_buf_n [WPR];
   logic [ST*BW-1:0]         r_buf_c [WPR];
   logic [BW-1:0]            r_prev_west;
   logic [NUM_POINTS*BW-1:0] r_ops [ST];
   logic [NUM_POINTS*BW-1:0] r_wt;
   logic [LATENCY-1:0]       r_vld;
   logic                     r_out_valid;

   logic                     w_trigger;
   logic [ST*BW-1:0]         w_n_word;
   logic [ST*BW-1:0]         w_c_word;
   logic [BW-1:0]            w_west_edge;
   logic [BW-1:0]            w_east_edge;
   logic [NUM_POINTS*BW-1:0] w_ops [ST];
   logic [BW-1:0]            w_lane_out [ST];

   assign w_trigger   = io_in_ready && (r_row >= FIRST_TRIG_ROW);
   assign w_n_word    = r_buf_n[r_word];
   assign w_c_word    = r_buf_c[r_word];
   // The west word's slot is already overwritten by the new row, so its last lane is kept aside.
   assign w_west_edge = (r_word == '0) ? '0 : r_prev_west;
   assign w_east_edge = (r_word == LAST_WORD) ? '0 : r_buf_c[r_word + WW'(1)][BW-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < ST; gi++) begin : g_lane
         logic [BW-1:0] w_west;
         logic [BW-1:0] w_east;
         if (gi == 0) begin : g_w_edge
            assign w_west = w_west_edge;
         end else begin : g_w_in
            assign w_west = w_c_word[(gi-1)*BW +: BW];
         end
         if (gi == ST - 1) begin : g_e_edge
            assign w_east = w_east_edge;
         end else begin : g_e_in
            assign w_east = w_c_word[(gi+1)*BW +: BW];
         end
         assign w_ops[gi] = {io_in_matrix[gi*BW +: BW], w_east, w_c_word[gi*BW +: BW],
                             w_west, w_n_word[gi*BW +: BW]};

         fp32_mul_add_lane u_lane (
            .clock    (clock),
            .reset    (reset),
            .i_en_out (r_vld[LATENCY-1]),
            .i_x      (r_ops[gi]),
            .i_wt     (r_wt),
            .o_data   (w_lane_out[gi])
         );
         assign io_out_data[gi*BW +: BW] = w_lane_out[gi];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_row       <= '0;
         r_word      <= '0;
         r_vld       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_vld       <= {r_vld[LATENCY-2:0], w_trigger};
         r_out_valid <= r_vld[LATENCY-1];
         if (io_in_ready) begin
            if (r_word == LAST_WORD) begin
               r_word <= '0;
               r_row  <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
            end else begin
               r_word <= r_word + WW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (io_in_ready) begin
         r_buf_n[r_word] <= w_c_word;
         r_buf_c[r_word] <= io_in_matrix;
         r_prev_west     <= w_c_word[ST*BW-1 -: BW];
      end
      if (w_trigger) begin
         r_ops <= w_ops;
         r_wt  <= io_in_weight;
      end
   end

   assign io_out_valid = r_out_valid;
endmodule

// File: tb/tb_soda_2d_cross_stencil.sv
// Scoreboard bench: expected words and due cycles are queued at acceptance, checked on io_out_valid.
module tb_soda_2d_cross_stencil;
   import soda_pkg::*;

   logic                     clock = 1'b0;
   logic                     reset;
   logic                     io_in_ready;
   logic [ST*BW-1:0]         io_in_matrix;
   logic [NUM_POINTS*BW-1:0] io_in_weight;
   logic [ST*BW-1:0]         io_out_data;
   logic                     io_out_valid;

   soda_2d_cross_stencil dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_ready  (io_in_ready),
      .io_in_matrix (io_in_matrix),
      .io_in_weight (io_in_weight),
      .io_out_data  (io_out_data),
      .io_out_valid (io_out_valid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [ST*BW-1:0] data;
      int               due;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   real  xf [ROW][COL];
   real  wt_cur [NUM_POINTS];
   int   m_row  = 0;
   int   m_word = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Exact-valued doubles only: re-bias exponent, drop the low mantissa bits.
   function automatic logic [31:0] to_f32(input real v);
      logic [63:0] bits;
      logic [10:0] e11;
      bits = $realtobits(v);
      if (bits[62:52] == 11'd0) return {bits[63], 31'd0};
      e11 = bits[62:52] - 11'd896;
      return {bits[63], e11[7:0], bits[51:29]};
   endfunction

   function automatic logic [ST*BW-1:0] exp_word(input int r, input int w);
      logic [ST*BW-1:0] res;
      real n, we, c, e, s;
      for (int k = 0; k < ST; k++) begin
         int col = w * ST + k;
         n  = wt_cur[W_N] * xf[r-1][col];
         we = wt_cur[W_W] * ((col > 0) ? xf[r][col-1] : 0.0);
         c  = wt_cur[W_C] * xf[r][col];
         e  = wt_cur[W_E] * ((col < COL - 1) ? xf[r][col+1] : 0.0);
         s  = wt_cur[W_S] * xf[r+1][col];
         res[k*BW +: BW] = to_f32(((n + we) + (c + e)) + s);
      end
      return res;
   endfunction

   task automatic set_frame(input int mode, input real wn, input real ww, input real wc,
                            input real we, input real ws);
      for (int r = 0; r < ROW; r++) begin
         for (int c = 0; c < COL; c++) begin
            case (mode)
               0:       xf[r][c] = 1.0;
               1:       xf[r][c] = real'(r * COL + c);
               default: xf[r][c] = real'(r * COL + c + 1) * 0.5;
            endcase
         end
      end
      wt_cur[W_N] = wn;
      wt_cur[W_W] = ww;
      wt_cur[W_C] = wc;
      wt_cur[W_E] = we;
      wt_cur[W_S] = ws;
   endtask

   // Called at a negedge; the posedge in between decides acceptance.
   task automatic step(input logic rdy);
      logic [ST*BW-1:0] d;
      exp_t             ex;
      for (int k = 0; k < ST; k++) d[k*BW +: BW] = to_f32(xf[m_row][m_word*ST + k]);
      io_in_ready  = rdy;
      io_in_matrix = d;
      io_in_weight = {to_f32(wt_cur[W_S]), to_f32(wt_cur[W_E]), to_f32(wt_cur[W_C]),
                      to_f32(wt_cur[W_W]), to_f32(wt_cur[W_N])};
      @(negedge clock);
      if (rdy) begin
         if (m_row >= 2) begin
            ex.data = exp_word(m_row - 1, m_word);
            ex.due  = cyc + LATENCY;
            sb_q.push_back(ex);
         end
         if (m_word == WPR - 1) begin
            m_word = 0;
            m_row  = (m_row == ROW - 1) ? 0 : m_row + 1;
         end else begin
            m_word++;
         end
      end
   endtask

   task automatic run_words(input int nwords, input bit gaps);
      for (int i = 0; i < nwords; i++) begin
         step(1'b1);
         if (gaps) step(1'b0);
      end
      io_in_ready = 1'b0;
   endtask

   task automatic drain_and_count(input string tag, input int n_before, input int n_expect);
      io_in_ready = 1'b0;
      repeat (LATENCY + 3) @(negedge clock);
      chk({tag, "_count"}, 64'(n_out - n_before), 64'(n_expect));
      chk({tag, "_queue_empty"}, 64'(sb_q.size()), 64'd0);
      $display("%s: %0d outputs checked", tag, n_out - n_before);
   endtask

   always @(negedge clock) begin
      if (io_out_valid === 1'b1) begin
         n_assert++;
         assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_valid observed=1 expected=0 at cycle %0d", cyc);
         end
         if (sb_q.size() > 0) begin
            exp_t ex;
            ex = sb_q.pop_front();
            chk($sformatf("out%0d_data", n_out), 64'(io_out_data), 64'(ex.data));
            chk($sformatf("out%0d_cycle", n_out), 64'(cyc), 64'(ex.due));
            $display("out %0d: data=%h cycle=%0d", n_out, io_out_data, cyc);
            n_out++;
         end
      end
   end

   initial begin
      int n0;
      reset        = 1'b1;
      io_in_ready  = 1'b0;
      io_in_matrix = '0;
      io_in_weight = '0;
      repeat (3) @(negedge clock);
      chk("reset_valid", 64'(io_out_valid), 64'd0);
      chk("reset_data", 64'(io_out_data), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Identity (center only) on an all-ones frame.
      n0 = n_out;
      set_frame(0, 0.0, 0.0, 1.0, 0.0, 0.0);
      run_words(ROW * WPR, 1'b0);
      drain_and_count("identity", n0, 24);

      // All-ones weights: edges lose one neighbour.
      n0 = n_out;
      set_frame(0, 1.0, 1.0, 1.0, 1.0, 1.0);
      run_words(ROW * WPR, 1'b0);
      drain_and_count("sum5", n0, 24);

      // Laplacian over a ramp.
      n0 = n_out;
      set_frame(1, 1.0, 1.0, -4.0, 1.0, 1.0);
      run_words(ROW * WPR, 1'b0);
      drain_and_count("laplacian", n0, 24);

      // Same frame with ready toggling every cycle.
      n0 = n_out;
      run_words(ROW * WPR, 1'b1);
      drain_and_count("laplacian_gaps", n0, 24);

      // Two back-to-back frames with different data and weights.
      n0 = n_out;
      run_words(ROW * WPR, 1'b0);
      set_frame(2, 0.5, -1.5, 2.0, 0.25, 3.0);
      run_words(ROW * WPR, 1'b0);
      drain_and_count("back_to_back", n0, 48);

      // Reset after 20 accepted words, then a fresh frame.
      run_words(20, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      sb_q.delete();
      m_row  = 0;
      m_word = 0;
      chk("midreset_valid", 64'(io_out_valid), 64'd0);
      chk("midreset_data", 64'(io_out_data), 64'd0);
      reset = 1'b0;
      repeat (LATENCY + 2) @(negedge clock);
      n0 = n_out;
      run_words(ROW * WPR, 1'b0);
      drain_and_count("after_reset", n0, 24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
